// File: rtl/fp_sqrt_pkg.sv
// Shared types and helpers for the iterative floating-point square-root unit.
// Latency: n/a (declarations only). Backpressure: n/a.
// Holds FSM encodings, flag bit positions and NaN helpers sized by format.
package fp_sqrt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int NV = 1;
    localparam int NX = 0;

    // Canonical quiet NaN right-aligned in 64 bits: exponent all ones plus mantissa MSB.
    function automatic logic [63:0] canon_qnan(input int exp_w, input int man_w);
        logic [63:0] ones;
        ones = (64'd1 << (exp_w + 1)) - 64'd1;
        return ones << (man_w - 1);
    endfunction

    function automatic logic is_snan(input logic exp_ones, input logic quiet_bit, input logic man_nz);
        return exp_ones & ~quiet_bit & man_nz;
    endfunction

endpackage

// File: rtl/fp_sqrt_iter_step.sv
// One restoring square-root step: consumes a radicand bit pair, yields one root bit.
// Latency: combinational. Backpressure: none.
// RW must equal QW+2; the stored remainder never exceeds twice the root so it fits RW bits.
module sqrt_iter_step #(
    parameter int RW = 28,
    parameter int QW = 26
) (
    input  logic [RW-1:0] rem,
    input  logic [QW-1:0] root,
    input  logic [1:0]    pair,
    output logic [RW-1:0] rem_nxt,
    output logic          root_bit
);

    logic [RW+1:0] cur;
    logic [RW+1:0] trial;
    logic [RW-1:0] diff;

    assign cur      = {rem, pair};
    assign trial    = {2'b00, root, 2'b01};
    assign root_bit = (cur >= trial);
    // Only taken when cur >= trial, and then the difference fits in RW bits.
    assign diff     = cur[RW-1:0] - trial[RW-1:0];
    assign rem_nxt  = root_bit ? diff : cur[RW-1:0];

endmodule

// File: rtl/fp_sqrt_iter.sv
// Iterative IEEE-754 square root, one root bit per cycle, round-to-nearest-even.
// Latency: ITER+2 edges counting the accept edge (specials: the accept edge itself).
// Backpressure: result held until out_ready; in_ready only while idle.
module fp_sqrt_iter
    import fp_sqrt_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     in_a,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     out_result,
    output logic [1:0]               out_flags
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int BIAS = 2**(EXP_W-1) - 1;
    localparam int ITER = MAN_W + 3;
    localparam int RW   = MAN_W + 5;
    localparam int RADW = 2 * ITER;
    localparam int CW   = $clog2(ITER + 1);
    localparam logic [EXP_W:0] BIAS_V = (EXP_W+1)'(BIAS);
    localparam logic [63:0]    QNAN64 = canon_qnan(EXP_W, MAN_W);
    localparam logic [W-1:0]   QNAN   = QNAN64[W-1:0];

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [RADW-1:0]   rad_q;
    logic [RW-1:0]     rem_q;
    logic [ITER-1:0]   root_q;
    logic [EXP_W-1:0]  exp_q;

    logic              sgn, exp_ones, exp_zero, man_nz, is_nan, odd;
    logic [EXP_W-1:0]  ex;
    logic [MAN_W-1:0]  mn;
    logic [EXP_W:0]    exp_sum;
    logic [EXP_W-1:0]  res_exp;
    logic [RADW-1:0]   rad_init;
    logic [MAN_W+1:0]  mant2;

    assign sgn      = in_a[W-1];
    assign ex       = in_a[W-2:MAN_W];
    assign mn       = in_a[MAN_W-1:0];
    assign exp_ones = &ex;
    assign exp_zero = ~|ex;
    assign man_nz   = |mn;
    assign is_nan   = exp_ones & man_nz;
    // Unbiased exponent parity; an odd exponent moves one factor of two into the radicand.
    assign odd      = ex[0] ^ BIAS_V[0];
    assign exp_sum  = {1'b0, ex} + BIAS_V - {{EXP_W{1'b0}}, odd};
    assign res_exp  = EXP_W'(exp_sum >> 1);
    assign mant2    = odd ? {1'b1, mn, 1'b0} : {2'b01, mn};
    assign rad_init = {mant2, {(MAN_W+4){1'b0}}};

    logic          special, sp_nv;
    logic [W-1:0]  sp_res;

    always_comb begin
        special = 1'b1;
        sp_nv   = 1'b0;
        sp_res  = '0;
        if (is_nan) begin
            sp_res = QNAN;
            sp_nv  = is_snan(exp_ones, mn[MAN_W-1], man_nz);
        end else if (exp_zero) begin
            sp_res = {sgn, {(W-1){1'b0}}};
        end else if (sgn) begin
            sp_res = QNAN;
            sp_nv  = 1'b1;
        end else if (exp_ones) begin
            sp_res = in_a;
        end else begin
            special = 1'b0;
        end
    end

    logic [RW-1:0] rem_nxt;
    logic          root_bit;

    sqrt_iter_step #(.RW(RW), .QW(ITER)) u_step (
        .rem      (rem_q),
        .root     (root_q),
        .pair     (rad_q[RADW-1 -: 2]),
        .rem_nxt  (rem_nxt),
        .root_bit (root_bit)
    );

    logic              guard, sticky, inc, carry;
    logic [MAN_W+1:0]  sum_m;
    logic [MAN_W-1:0]  mant_r;
    logic [EXP_W-1:0]  exp_r;

    assign guard  = root_q[1];
    assign sticky = root_q[0] | (|rem_q);
    assign inc    = guard & (sticky | root_q[2]);
    assign sum_m  = {1'b0, root_q[ITER-1:2]} + {{(MAN_W+1){1'b0}}, inc};
    assign carry  = sum_m[MAN_W+1];
    assign mant_r = carry ? sum_m[MAN_W:1] : sum_m[MAN_W-1:0];
    assign exp_r  = exp_q + {{(EXP_W-1){1'b0}}, carry};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            rad_q      <= '0;
            rem_q      <= '0;
            root_q     <= '0;
            exp_q      <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    in_ready <= 1'b0;
                    if (special) begin
                        out_result    <= sp_res;
                        out_flags[NV] <= sp_nv;
                        out_flags[NX] <= 1'b0;
                        out_valid     <= 1'b1;
                        state         <= DONE;
                    end else begin
                        rad_q  <= rad_init;
                        rem_q  <= '0;
                        root_q <= '0;
                        cnt    <= '0;
                        exp_q  <= res_exp;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    rem_q  <= rem_nxt;
                    root_q <= {root_q[ITER-2:0], root_bit};
                    rad_q  <= {rad_q[RADW-3:0], 2'b00};
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(ITER - 1))
                        state <= ROUND;
                end
                ROUND: begin
                    out_result    <= {1'b0, exp_r, mant_r};
                    out_flags[NV] <= 1'b0;
                    out_flags[NX] <= guard | sticky;
                    out_valid     <= 1'b1;
                    state         <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
